ring_counter_param: RTL and testbench
=====================================

// Module: ring_counter_param
// PURPOSE
// - Parametrised WIDTH-bit shift-register counter; generation-2 successor of the fixed 4-bit ring counter.
// - Run-time ring/Johnson mode select, up/down shift direction, count enable and arbitrary parallel load.
// - Step counter with a one-cycle wrap pulse.
// - Used as a one-hot sequencer / phase generator (scan strobes, TDM slot select) in the counter library.
// PARAMETERS
// - WIDTH  4  number of stages; legal range 2..32
// - SW     $clog2(2*WIDTH)  width of step output (localparam, not overridable)
// PORTS
// - clk       in   1      single clock; all state updates on posedge clk
// - clr       in   1      reset: synchronous, active-high; highest priority
// - load      in   1      parallel load of load_val into q
// - load_val  in   WIDTH  pattern loaded when load=1
// - en        in   1      advance one shift per cycle while high
// - dir       in   1      0 = shift toward MSB, 1 = shift toward LSB
// - mode      in   1      0 = ring (period WIDTH), 1 = Johnson/twisted (period 2*WIDTH)
// - q         out  WIDTH  counter state, registered
// - step      out  SW     shifts since last clr/load/mode change, modulo period
// - wrap      out  1      registered pulse: high in the cycle step returns to 0 by shifting
// - err       out  1      illegal-state pulse (RINGCNT_SELFCORR_EN only; else tied 0)
// BEHAVIOUR
// - Reset (clr=1 at posedge): q=0, step=0, wrap=0, err=0, mode_q=mode. Independent of load/en.
// - Priority per posedge: clr > load > mode change > en > hold.
// - load=1: q<=load_val, step<=0, wrap<=0. en is ignored that cycle.
// - mode change: mode_q registers mode every cycle. If mode!=mode_q and no clr/load:
//     step<=0, wrap<=0, q holds, no shift that cycle.
// - Shift when en=1 (next q):
//     ring up   {q[W-2:0], q[W-1]}    ring down   {q[0], q[W-1:1]}
//     john up   {q[W-2:0], ~q[W-1]}   john down   {~q[0], q[W-1:1]}
// - Step counter: on each shift, step<=(step==P-1)?0:step+1, with P=WIDTH (ring) or 2*WIDTH (Johnson).
//     wrap<=1 exactly when step goes P-1 -> 0 by a shift; otherwise wrap<=0.
// - dir change mid-run: no effect on step; shift reverses on the next cycle.
// - en=0: q, step hold; wrap<=0.
// - Output latency: one cycle from any input to q/step/wrap. All outputs are registers; no comb paths.
// - Ring mode after clr: q=0 is a stuck state (shifts to 0). Software must load a seed.
// - Illegal state, ring: popcount(q)!=1.
// - Illegal state, Johnson: popcount(q[W-1:1]^q[W-2:0]) > 1 (more than one 0/1 boundary).
// CONFIGURATION
// - Macro RINGCNT_SELFCORR_EN defined (self-correction compiled in):
//     - When en=1, no clr/load/mode change, and q is illegal for the current mode, the shift is replaced.
//     - Replacement: q<=1 (bit0 only, ring) or q<=0 (Johnson); step<=0, wrap<=0.
//     - err<=1 for that one cycle; err=0 in all other cycles.
// - Macro undefined: no detection logic; err tied 0; illegal patterns shift per the normal equations.
// TESTING
// - WIDTH=4: clr; load 0001; mode=0 dir=0 en=1 x4 -> q=0010,0100,1000,0001; step 1,2,3,0.
//     wrap=1 only with the final 0001.
// - Johnson: load 0000, mode=1 dir=0 en=1 x8 -> q=0001,0011,0111,1111,1110,1100,1000,0000.
//     wrap=1 only on the 8th shift.
// - Down: load 0001, mode=0 dir=1 en=1 x2 -> q=1000,0100.
//     Then dir=0 x1 -> q=1000, step=3.
// - Priority: clr=1 with load=1 -> q=0000, step=0. load=1 with en=1 and load_val=0100 -> q=0100, step=0.
// - Hold and mode change: en=0 for 3 cycles -> q, step unchanged, wrap=0.
//     Toggle mode with en=1 -> q unchanged, step=0, no wrap.
// - Self-correction: load 0110, mode=0, en=1.
//     With RINGCNT_SELFCORR_EN -> q=0001, err=1 for 1 cycle.
//     Without -> q=1100, err=0.

Source files
------------

// File: rtl/ring_counter_param.sv
// Parametrised ring/Johnson shift counter with step counter and wrap pulse.
// Optional self-correction of illegal states: define RINGCNT_SELFCORR_EN.
module ring_counter_param #(
  parameter int WIDTH = 4,
  localparam int SW = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic [SW-1:0]    step,
  output logic             wrap,
  output logic             err
);

  logic             mode_q;
  logic [WIDTH-1:0] nxt;
  logic [SW-1:0]    plast;
  logic             at_last;
  logic             ill;

  always_comb begin
    nxt = q;
    unique case ({mode, dir})
      2'b00: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b01: nxt = {q[0], q[WIDTH-1:1]};
      2'b10: nxt = {q[WIDTH-2:0], ~q[WIDTH-1]};
      2'b11: nxt = {~q[0], q[WIDTH-1:1]};
      default: nxt = q;
    endcase
  end

  assign plast   = mode ? SW'(2 * WIDTH - 1) : SW'(WIDTH - 1);
  assign at_last = (step == plast);

`ifdef RINGCNT_SELFCORR_EN
  // Johnson legality: at most one 0/1 boundary along the register
  always_comb begin
    ill = 1'b0;
    if (mode)
      ill = ($countones(q[WIDTH-1:1] ^ q[WIDTH-2:0]) > 1);
    else
      ill = ($countones(q) != 1);
  end

  always_ff @(posedge clk) begin
    if (clr)
      err <= 1'b0;
    else
      err <= !load && (mode == mode_q) && en && ill;
  end
`else
  assign ill = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (clr) begin
      q    <= '0;
      step <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      step <= '0;
      wrap <= 1'b0;
    end else if (mode != mode_q) begin
      step <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (ill) begin
        q    <= mode ? '0 : WIDTH'(1);
        step <= '0;
        wrap <= 1'b0;
      end else begin
        q    <= nxt;
        step <= at_last ? '0 : step + SW'(1);
        wrap <= at_last;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_counter_param.sv
// Bench for ring_counter_param: directed steps then random traffic
// against a behavioural model of the counter rules.
module tb_ring_counter_param;

  localparam int W  = 4;
  localparam int SW = $clog2(2 * W);

`ifdef RINGCNT_SELFCORR_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  q;
  logic [SW-1:0] step;
  logic          wrap;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq;
  int           ms;
  bit           mw, me, mm;

  ring_counter_param #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .mode(mode),
    .q(q), .step(step), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic int ones(logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int edges(logic [W-1:0] v);
    int n = 0;
    for (int i = 1; i < W; i++) if (v[i] != v[i-1]) n++;
    return n;
  endfunction

  // Bit leaving one end re-enters the other, inverted in Johnson mode
  function automatic logic [W-1:0] rot(logic [W-1:0] v, bit m, bit d);
    logic o, b;
    o = d ? v[0] : v[W-1];
    b = m ? ~o : o;
    if (!d) return (v << 1) | W'(b);
    return (v >> 1) | (W'(b) << (W - 1));
  endfunction

  function automatic void model(bit c, bit l, logic [W-1:0] lv,
                                bit e, bit d, bit m);
    int  p = m ? 2 * W : W;
    bit  bad = m ? (edges(mq) > 1) : (ones(mq) != 1);
    me = 1'b0;
    if (c) begin
      mq = '0; ms = 0; mw = 0;
    end else if (l) begin
      mq = lv; ms = 0; mw = 0;
    end else if (m != mm) begin
      ms = 0; mw = 0;
    end else if (e) begin
      if (SC && bad) begin
        mq = m ? '0 : W'(1); ms = 0; mw = 0; me = 1;
      end else begin
        mq = rot(mq, m, d);
        mw = (ms == p - 1);
        ms = (ms + 1) % p;
      end
    end else begin
      mw = 0;
    end
    mm = m;
  endfunction

  task automatic tick(input bit c, input bit l, input logic [W-1:0] lv,
                      input bit e, input bit d, input bit m);
    clr = c; load = l; load_val = lv; en = e; dir = d; mode = m;
    model(c, l, lv, e, d, m);
    @(posedge clk);
    #1;
    chk("q", 32'(q), 32'(mq));
    chk("step", 32'(step), 32'(ms));
    chk("wrap", 32'(wrap), 32'(mw));
    chk("err", 32'(err), 32'(me));
  endtask

  logic [W-1:0] rexp [4];
  logic [W-1:0] jexp [8];

  initial begin
    rexp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    jexp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
             4'b1110, 4'b1100, 4'b1000, 4'b0000};
    mm = 1'b0;

    tick(1, 0, '0, 0, 0, 0);
    chk("reset_q", 32'(q), 0);
    chk("reset_step", 32'(step), 0);

    tick(0, 1, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, '0, 1, 0, 0);
      chk("ring_q", 32'(q), 32'(rexp[i]));
      chk("ring_step", 32'(step), 32'((i + 1) % 4));
      chk("ring_wrap", 32'(wrap), 32'(i == 3));
    end

    tick(0, 1, 4'b0000, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, '0, 1, 0, 1);
      chk("john_q", 32'(q), 32'(jexp[i]));
      chk("john_wrap", 32'(wrap), 32'(i == 7));
    end

    tick(0, 1, 4'b0001, 0, 1, 0);
    tick(0, 0, '0, 1, 1, 0);
    chk("down_q1", 32'(q), 32'(4'b1000));
    tick(0, 0, '0, 1, 1, 0);
    chk("down_q2", 32'(q), 32'(4'b0100));
    tick(0, 0, '0, 1, 0, 0);
    chk("rev_q", 32'(q), 32'(4'b1000));
    chk("rev_step", 32'(step), 3);

    tick(1, 1, 4'b1111, 1, 0, 0);
    chk("clr_load_q", 32'(q), 0);
    tick(0, 1, 4'b0100, 1, 0, 0);
    chk("load_en_q", 32'(q), 32'(4'b0100));
    chk("load_en_step", 32'(step), 0);

    tick(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, '0, 0, 0, 0);
      chk("hold_q", 32'(q), 32'(4'b1000));
      chk("hold_step", 32'(step), 1);
    end
    tick(0, 0, '0, 1, 0, 1);
    chk("mchg_q", 32'(q), 32'(4'b1000));
    chk("mchg_step", 32'(step), 0);
    chk("mchg_wrap", 32'(wrap), 0);

    tick(0, 1, 4'b0110, 0, 0, 0);
    tick(0, 0, '0, 1, 0, 0);
`ifdef RINGCNT_SELFCORR_EN
    chk("corr_q", 32'(q), 32'(4'b0001));
    chk("corr_err", 32'(err), 1);
    tick(0, 0, '0, 1, 0, 0);
    chk("corr_err_drop", 32'(err), 0);
`else
    chk("corr_q", 32'(q), 32'(4'b1100));
    chk("corr_err", 32'(err), 0);
`endif

    for (int i = 0; i < 400; i++) begin
      bit c, l, m;
      c = ($urandom_range(31) == 0);
      l = ($urandom_range(7) == 0);
      m = ($urandom_range(15) == 0) ? ~mode : mode;
      tick(c, l, W'($urandom), $urandom_range(3) != 0,
           1'($urandom), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
